// File: rtl/fpu_addsub_param.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_addsub_param
//  Description : Multi-cycle parametrised floating-point adder/subtractor with
//                start/busy/done handshake and round-to-nearest-even.
//                Word format {sign, exponent[EXP_W], mantissa[MAN_W]},
//                hidden leading one, exponent field 0 means zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_addsub_param #(
    parameter  int EXP_W = 10,
    parameter  int MAN_W = 21,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clock_100Khz,
    input  logic         reset,
    input  logic         start_in,
    input  logic         op_sub_in,
    input  logic [W-1:0] Op_A_in,
    input  logic [W-1:0] Op_B_in,
    output logic         busy_out,
    output logic         done_out,
    output logic [W-1:0] data_out,
    output logic [3:0]   status_out
);

    // Mantissa with hidden bit, the same extended by G/R/S, exponent with headroom
    localparam int MW = MAN_W + 1;
    localparam int XW = MAN_W + 4;
    localparam int EW = EXP_W + 1;

    localparam logic [EW-1:0]    EXP_MAX   = EW'((1 << EXP_W) - 1);
    localparam logic [EW-1:0]    EXP_ONE   = EW'(1);
    localparam logic [EXP_W-1:0] ALIGN_LIM = EXP_W'(XW);

    localparam logic [3:0] ST_OVERFLOW  = 4'd0;
    localparam logic [3:0] ST_UNDERFLOW = 4'd1;
    localparam logic [3:0] ST_EXACT     = 4'd2;
    localparam logic [3:0] ST_INEXACT   = 4'd3;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DECODE    = 3'd1,
        S_ALIGN     = 3'd2,
        S_OPERATE   = 3'd3,
        S_NORMALIZE = 3'd4,
        S_ROUND     = 3'd5,
        S_WRITEBACK = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d;
    logic             sub_q, sub_d;
    logic             big_sign_q, big_sign_d, small_sign_q, small_sign_d;
    logic [MW-1:0]    big_man_q, big_man_d, small_man_q, small_man_d;
    logic [EW-1:0]    exp_q, exp_d;
    logic [EXP_W-1:0] diff_q, diff_d;
    logic             special_q, special_d;
    logic [XW-1:0]    aligned_q, aligned_d;
    logic [XW-1:0]    mant_q, mant_d;
    logic             carry_q, carry_d;
    logic             sign_q, sign_d;
    logic             inexact_q, inexact_d;
    logic [W-1:0]     data_q, data_d;
    logic [3:0]       status_q, status_d;
    logic             done_q, done_d;

    // Operand field views and intermediate arithmetic
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [MW-1:0]    man_a, man_b;
    logic             sign_b_eff;
    logic [XW-1:0]    small_ext, lost_mask, big_ext;
    logic [MW-1:0]    rnd_man;
    logic             rnd_inc;
    logic [MW:0]      rnd_sum;

    assign exp_a      = a_q[W-2:MAN_W];
    assign exp_b      = b_q[W-2:MAN_W];
    assign man_a      = (exp_a == '0) ? '0 : {1'b1, a_q[MAN_W-1:0]};
    assign man_b      = (exp_b == '0) ? '0 : {1'b1, b_q[MAN_W-1:0]};
    assign sign_b_eff = b_q[W-1] ^ sub_q;
    assign small_ext  = {small_man_q, 3'b000};
    assign big_ext    = {big_man_q, 3'b000};
    assign lost_mask  = ~({XW{1'b1}} << diff_q);
    assign rnd_man    = mant_q[XW-1:3];
    assign rnd_inc    = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
    assign rnd_sum    = {1'b0, rnd_man} + {{MW{1'b0}}, rnd_inc};

    // Next-state and datapath updates for every stage of the operation
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        sub_d        = sub_q;
        big_sign_d   = big_sign_q;
        small_sign_d = small_sign_q;
        big_man_d    = big_man_q;
        small_man_d  = small_man_q;
        exp_d        = exp_q;
        diff_d       = diff_q;
        special_d    = special_q;
        aligned_d    = aligned_q;
        mant_d       = mant_q;
        carry_d      = carry_q;
        sign_d       = sign_q;
        inexact_d    = inexact_q;
        data_d       = data_q;
        status_d     = status_q;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    a_d     = Op_A_in;
                    b_d     = Op_B_in;
                    sub_d   = op_sub_in;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                special_d = (exp_a == '1) || (exp_b == '1);
                // A wins ties so equal exponents give diff = 0 with A as big
                if (exp_b > exp_a) begin
                    big_sign_d   = sign_b_eff;
                    small_sign_d = a_q[W-1];
                    big_man_d    = man_b;
                    small_man_d  = man_a;
                    exp_d        = {1'b0, exp_b};
                    diff_d       = exp_b - exp_a;
                end else begin
                    big_sign_d   = a_q[W-1];
                    small_sign_d = sign_b_eff;
                    big_man_d    = man_a;
                    small_man_d  = man_b;
                    exp_d        = {1'b0, exp_a};
                    diff_d       = exp_a - exp_b;
                end
                state_d = S_ALIGN;
            end
            S_ALIGN: begin
                if (diff_q >= ALIGN_LIM) begin
                    aligned_d = {{(XW-1){1'b0}}, |small_man_q};
                end else begin
                    aligned_d = (small_ext >> diff_q)
                              | {{(XW-1){1'b0}}, |(small_ext & lost_mask)};
                end
                state_d = S_OPERATE;
            end
            S_OPERATE: begin
                sign_d  = big_sign_q;
                carry_d = 1'b0;
                if (big_sign_q == small_sign_q) begin
                    {carry_d, mant_d} = {1'b0, big_ext} + {1'b0, aligned_q};
                end else if (big_ext >= aligned_q) begin
                    mant_d = big_ext - aligned_q;
                end else begin
                    // Only reachable on equal exponents with B the larger magnitude
                    mant_d = aligned_q - big_ext;
                    sign_d = small_sign_q;
                end
                state_d = S_NORMALIZE;
            end
            S_NORMALIZE: begin
                if (carry_q) begin
                    mant_d  = {1'b1, mant_q[XW-1:2], mant_q[1] | mant_q[0]};
                    carry_d = 1'b0;
                    exp_d   = exp_q + EXP_ONE;
                end else if (mant_q == '0) begin
                    sign_d  = 1'b0;
                    state_d = S_ROUND;
                end else if (!mant_q[XW-1] && (exp_q > EXP_ONE)) begin
                    mant_d = mant_q << 1;
                    exp_d  = exp_q - EXP_ONE;
                end else begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                inexact_d = mant_q[2] | mant_q[1] | mant_q[0];
                if (rnd_sum[MW]) begin
                    mant_d = {rnd_sum[MW:1], 3'b000};
                    exp_d  = exp_q + EXP_ONE;
                end else begin
                    mant_d = {rnd_sum[MW-1:0], 3'b000};
                end
                state_d = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                if ((exp_q >= EXP_MAX) || special_q) begin
                    data_d   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    status_d = ST_OVERFLOW;
                end else if ((rnd_man != '0) && !rnd_man[MW-1] && (exp_q == EXP_ONE)) begin
                    data_d   = '0;
                    status_d = ST_UNDERFLOW;
                end else if (rnd_man == '0) begin
                    data_d   = '0;
                    status_d = inexact_q ? ST_INEXACT : ST_EXACT;
                end else begin
                    data_d   = {sign_q, exp_q[EXP_W-1:0], rnd_man[MAN_W-1:0]};
                    status_d = inexact_q ? ST_INEXACT : ST_EXACT;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock_100Khz) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Datapath and result registers
    always_ff @(posedge clock_100Khz) begin
        if (reset) begin
            a_q          <= '0;
            b_q          <= '0;
            sub_q        <= 1'b0;
            big_sign_q   <= 1'b0;
            small_sign_q <= 1'b0;
            big_man_q    <= '0;
            small_man_q  <= '0;
            exp_q        <= '0;
            diff_q       <= '0;
            special_q    <= 1'b0;
            aligned_q    <= '0;
            mant_q       <= '0;
            carry_q      <= 1'b0;
            sign_q       <= 1'b0;
            inexact_q    <= 1'b0;
            data_q       <= '0;
            status_q     <= ST_EXACT;
            done_q       <= 1'b0;
        end else begin
            a_q          <= a_d;
            b_q          <= b_d;
            sub_q        <= sub_d;
            big_sign_q   <= big_sign_d;
            small_sign_q <= small_sign_d;
            big_man_q    <= big_man_d;
            small_man_q  <= small_man_d;
            exp_q        <= exp_d;
            diff_q       <= diff_d;
            special_q    <= special_d;
            aligned_q    <= aligned_d;
            mant_q       <= mant_d;
            carry_q      <= carry_d;
            sign_q       <= sign_d;
            inexact_q    <= inexact_d;
            data_q       <= data_d;
            status_q     <= status_d;
            done_q       <= done_d;
        end
    end

    assign busy_out   = (state_q != S_IDLE);
    assign done_out   = done_q;
    assign data_out   = data_q;
    assign status_out = status_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_addsub_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpu_addsub_param
//  Description : Directed self-checking bench for fpu_addsub_param with a
//                scoreboard of expected result, status and latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_addsub_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op_sub;
    logic [31:0] op_a, op_b;
    logic        busy_out, done_out;
    logic [31:0] data_out;
    logic [3:0]  status_out;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic [3:0]  status;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb[$];

    fpu_addsub_param #(.EXP_W(10), .MAN_W(21)) dut (
        .clock_100Khz (clk),
        .reset        (reset),
        .start_in     (start),
        .op_sub_in    (op_sub),
        .Op_A_in      (op_a),
        .Op_B_in      (op_b),
        .busy_out     (busy_out),
        .done_out     (done_out),
        .data_out     (data_out),
        .status_out   (status_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Drives one start cycle; returns #1 after the sampling edge
    task automatic start_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic sub, input bit push, input logic [31:0] ed,
                            input logic [3:0] es, input int el);
        exp_t e;
        op_a   = a;
        op_b   = b;
        op_sub = sub;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) begin
            e.tag = tag; e.data = ed; e.status = es; e.lat = el; e.t0 = cyc;
            sb.push_back(e);
        end
    endtask

    // Waits (bounded) for done_out and scores the oldest pending expectation
    task automatic wait_done(input string tag);
        exp_t e;
        bit   seen = 0;
        int   n    = 0;
        while (!seen && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (done_out) seen = 1;
        end
        check({tag, "_done"}, 32'(done_out), 32'd1);
        if (seen) begin
            check({tag, "_pending"}, 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check({e.tag, "_data"}, data_out, e.data);
                check({e.tag, "_status"}, 32'(status_out), 32'(e.status));
                check({e.tag, "_latency"}, 32'(cyc - e.t0), 32'(e.lat));
            end
        end
    endtask

    // Counts done pulses over a window where none may occur
    task automatic quiet(input string tag, input int cycles);
        int pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done_out) pulses++;
        end
        check({tag, "_no_done"}, 32'(pulses), 32'd0);
        check({tag, "_idle"}, 32'(busy_out), 32'd0);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        op_sub = 1'b0;
        op_a   = '0;
        op_b   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_done", 32'(done_out), 32'd0);
        check("rst_data", data_out, 32'h0);
        check("rst_status", 32'(status_out), 32'd2);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1.0 + 1.0: carry normalise, k = 2
        start_op("one_plus_one", 32'h3FE00000, 32'h3FE00000, 1'b0, 1, 32'h40000000, 4'd2, 7);
        check("busy_during_op", 32'(busy_out), 32'd1);
        wait_done("one_plus_one");
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done_out), 32'd0);
        check("data_held", data_out, 32'h40000000);

        start_op("three_minus_one", 32'h40100000, 32'h3FE00000, 1'b1, 1, 32'h40000000, 4'd2, 6);
        wait_done("three_minus_one");
        start_op("one_minus_one", 32'h3FE00000, 32'h3FE00000, 1'b1, 1, 32'h00000000, 4'd2, 6);
        wait_done("one_minus_one");

        // Rounding: exact tie stays even, above half rounds up
        start_op("rne_tie", 32'h3FE00000, 32'h3D200000, 1'b0, 1, 32'h3FE00000, 4'd3, 6);
        wait_done("rne_tie");
        start_op("rne_up", 32'h3FE00000, 32'h3D300000, 1'b0, 1, 32'h3FE00001, 4'd3, 6);
        wait_done("rne_up");

        // Overflow by sum and by all-ones input exponent
        start_op("max_plus_max", 32'h7FDFFFFF, 32'h7FDFFFFF, 1'b0, 1, 32'h7FE00000, 4'd0, 7);
        wait_done("max_plus_max");
        start_op("inf_input", 32'h7FE00000, 32'h3FE00000, 1'b0, 1, 32'h7FE00000, 4'd0, 6);
        wait_done("inf_input");

        start_op("underflow", 32'h00200001, 32'h00200000, 1'b1, 1, 32'h00000000, 4'd1, 6);
        wait_done("underflow");

        // Left normalise (1.5 - 1.0 = 0.5) and a negative result (1.0 - 3.0)
        start_op("left_norm", 32'h3FF00000, 32'h3FE00000, 1'b1, 1, 32'h3FC00000, 4'd2, 7);
        wait_done("left_norm");
        start_op("neg_result", 32'h3FE00000, 32'h40100000, 1'b1, 1, 32'hC0000000, 4'd2, 6);
        wait_done("neg_result");

        // start while busy is ignored: only the first operation completes
        start_op("busy_first", 32'h3FE00000, 32'h3FE00000, 1'b0, 1, 32'h40000000, 4'd2, 7);
        @(posedge clk);
        #1;
        start_op("busy_ignored", 32'h40100000, 32'h3FE00000, 1'b1, 0, 32'h0, 4'd0, 0);
        wait_done("busy_first");
        quiet("after_busy_start", 15);

        // Reset while in NORMALIZE aborts without done
        start_op("aborted", 32'h3FE00000, 32'h3FE00000, 1'b0, 0, 32'h0, 4'd0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("in_normalize_busy", 32'(busy_out), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_busy", 32'(busy_out), 32'd0);
        check("abort_done", 32'(done_out), 32'd0);
        check("abort_data", data_out, 32'h0);
        check("abort_status", 32'(status_out), 32'd2);
        quiet("after_abort", 12);

        // Clean restart, then back-to-back start in the done cycle
        start_op("restart", 32'h3FE00000, 32'h3FE00000, 1'b0, 1, 32'h40000000, 4'd2, 7);
        wait_done("restart");
        start_op("back_to_back", 32'h40100000, 32'h3FE00000, 1'b1, 1, 32'h40000000, 4'd2, 6);
        wait_done("back_to_back");
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpu_addsub_param.md
Name: fpu_addsub_param

Overview:
Parametrised multi-cycle floating-point adder/subtractor with a configurable exponent and mantissa width. It adds three features: a start/busy/done handshake, an add/subtract mode, and round-to-nearest-even using guard/round/sticky bits. It sits beside the datapath as a shared arithmetic unit, taking one operation at a time. The word format is {sign, exponent[EXP_W], mantissa[MAN_W]}, with a hidden leading 1 and bias 2^(EXP_W-1)-1.

Parameters:
EXP_W, 10, exponent field width
MAN_W, 21, stored mantissa field width (hidden bit excluded)
W (derived, not overridable), 1+EXP_W+MAN_W, total word width

Ports:
clock_100Khz  input  1  single clock; all logic rises on its posedge
reset  input  1  synchronous, active-high reset
start_in  input  1  request; sampled only while in IDLE
op_sub_in  input  1  0 = A+B, 1 = A-B; latched with the operands
Op_A_in  input  W  operand A; latched on the accepted start
Op_B_in  input  W  operand B; latched on the accepted start
busy_out  output  1  high in every state except IDLE
done_out  output  1  one-cycle pulse; data_out/status_out are valid from this cycle on
data_out  output  W  result; held until the next done_out
status_out  output  4  result code: 0 OVERFLOW, 1 UNDERFLOW, 2 EXACT, 3 INEXACT

Behaviour:
- Reset, synchronous and active-high:
  - state = IDLE; busy_out = 0, done_out = 0, data_out = 0, status_out = 2 (EXACT).
  - All internal registers are cleared.
  - Reset takes priority over everything; reset mid-operation aborts the operation with no done_out.
- States: IDLE -> DECODE -> ALIGN -> OPERATE -> NORMALIZE (k cycles) -> ROUND -> WRITEBACK -> IDLE.
- IDLE: start_in=1 latches Op_A_in, Op_B_in and op_sub_in, then moves to DECODE. start_in in any other state is ignored.
- DECODE:
  - Effective sign of B = Op_B[W-1] XOR op_sub.
  - Exponent field 0 means the operand is zero (hidden bit 0; no subnormals).
  - The operand with the larger exponent becomes "big"; on equal exponents, A is "big".
  - diff = exp_big - exp_small, unsigned.
- ALIGN:
  - The small mantissa (MAN_W+1 bits) is extended with 3 zero bits (G, R, S) and shifted right by diff.
  - S is the OR of all bits shifted past S.
  - If diff >= MAN_W+4, the aligned value is 0 and S = (small mantissa != 0).
- OPERATE:
  - Same effective signs: add with a carry bit.
  - Different signs: subtract the smaller magnitude from the larger; the result sign is the sign of the larger magnitude.
  - Result exponent = exp_big.
- NORMALIZE, at most one shift per cycle:
  - Carry set: shift right 1, S |= shifted-out bit, exp+1.
  - Otherwise, if MSB=0 and mantissa!=0 and exp>1: shift left 1, exp-1.
  - Otherwise: exit.
  - k = 1 + number of shifts; k <= MAN_W+5.
  - A zero mantissa exits immediately with a +0 result.
- ROUND:
  - Round-to-nearest-even on G, R, S: increment if G & (R | S | LSB).
  - A mantissa carry-out shifts right 1 and increments exp.
  - inexact = G | R | S (before rounding).
- WRITEBACK: results are registered; the next edge reaches IDLE with done_out=1 for one cycle. Status priority, first match wins:
  1. exp >= 2^EXP_W-1, or either input exponent is all ones: data_out = {sign, all ones, 0}, OVERFLOW.
  2. Nonzero mantissa with MSB=0 at exp=1: flush to data_out = 0, UNDERFLOW.
  3. inexact: INEXACT.
  4. Otherwise: EXACT.
  - An exact zero result is +0 (all zeros) with EXACT.
- Latency: done_out rises 5+k clocks after the edge that sampled start_in. A new start_in is accepted in the same cycle done_out is high.

Test Plan:
- 1.0+1.0 (A=0x3FE00000, B=0x3FE00000, sub=0) -> data_out=0x40000000, status 2, done_out 7 clocks after start (k=2).
- 3.0-1.0 (A=0x40100000, B=0x3FE00000, sub=1) -> 0x40000000, status 2. Then 1.0-1.0 -> 0x00000000, status 2, k=1, done at 6 clocks.
- 1.0+2^-22 (A=0x3FE00000, B=0x3D200000) -> tie, rounds to even: 0x3FE00000, status 3. Then B=0x3D300000 (2^-22 * 1.5) -> above half, rounds up: 0x3FE00001, status 3.
- Max+max (A=B=0x7FDFFFFF) -> 0x7FE00000, status 0. Also: A=0x7FE00000 input plus anything -> status 0.
- Underflow: A=0x00200001 minus B=0x00200000 -> 0x00000000, status 1.
- Handshake/reset: start_in pulsed while busy_out=1 is ignored (one done_out only). Reset asserted in NORMALIZE -> next cycle busy_out=0, data_out=0, status 2, no done_out. Operation restarts cleanly; back-to-back start_in in the done_out cycle is accepted.
